// File: rtl/lsu_wb.sv
`default_nettype none
// ============================================================================
// Module  : lsu_wb
// Brief   : LSU writeback stage - load data extraction/extension, registered
//           register-file write, stall while a load response is outstanding.
// Revision: 1.0
// ============================================================================
module lsu_wb #(
  parameter int DATA_W     = 32,
  parameter int WAIT_LIMIT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              is_load_in,
  input  logic              zero_ext_in,
  input  logic              is_nop_in,
  input  logic [1:0]        size_in,
  input  logic [4:0]        rd_in,
  input  logic [1:0]        addr_lo_in,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              rf_we,
  output logic [4:0]        rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              stall_out,
  output logic              misalign_err,
  output logic              timeout_err
);

  localparam int CNT_W = $clog2(WAIT_LIMIT + 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         size_q, size_d;
  logic [1:0]         lane_q, lane_d;
  logic               zext_q, zext_d;
  logic [4:0]         rd_q, rd_d;
  logic               rf_we_q, rf_we_d;
  logic [4:0]         rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0]  rf_wdata_q, rf_wdata_d;
  logic               mis_q, mis_d;
  logic               to_q, to_d;

  logic               accept;
  logic               misaligned;
  logic               capture;
  logic [1:0]         sel_size;
  logic [1:0]         sel_lane;
  logic               sel_zext;
  logic [4:0]         sel_rd;
  logic [DATA_W-1:0]  ext_data;

  function automatic logic [DATA_W-1:0] extend(
    input logic [DATA_W-1:0] word,
    input logic [1:0]        size,
    input logic [1:0]        lane,
    input logic              zext
  );
    logic [7:0]  b;
    logic [15:0] h;
    logic [DATA_W-1:0] res;
    b = word[{lane, 3'b000} +: 8];
    h = word[{lane[1], 4'b0000} +: 16];
    case (size)
      2'b00:   res = {{(DATA_W-8){~zext & b[7]}}, b};
      2'b01:   res = {{(DATA_W-16){~zext & h[15]}}, h};
      default: res = word;
    endcase
    return res;
  endfunction

  assign accept = (state_q == S_IDLE) && is_load_in && !is_nop_in;

  always_comb begin
    misaligned = 1'b0;
    case (size_in)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = addr_lo_in[0];
      default: misaligned = (addr_lo_in != 2'b00);
    endcase
  end

  // In WAIT the EX/WB inputs may already belong to the next op; use the latched copy.
  assign sel_size = (state_q == S_WAIT) ? size_q : size_in;
  assign sel_lane = (state_q == S_WAIT) ? lane_q : addr_lo_in;
  assign sel_zext = (state_q == S_WAIT) ? zext_q : zero_ext_in;
  assign sel_rd   = (state_q == S_WAIT) ? rd_q   : rd_in;
  assign ext_data = extend(mem_rdata, sel_size, sel_lane, sel_zext);

  assign capture   = mem_rvalid && ((accept && !misaligned) || (state_q == S_WAIT));
  assign stall_out = (state_q == S_WAIT) || (accept && !misaligned && !mem_rvalid);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    size_d     = size_q;
    lane_d     = lane_q;
    zext_d     = zext_q;
    rd_d       = rd_q;
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    mis_d      = 1'b0;
    to_d       = 1'b0;

    if (capture && (sel_rd != 5'd0)) begin
      rf_we_d    = 1'b1;
      rf_waddr_d = sel_rd;
      rf_wdata_d = ext_data;
    end

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          size_d = size_in;
          lane_d = addr_lo_in;
          zext_d = zero_ext_in;
          rd_d   = rd_in;
          if (misaligned) begin
            mis_d = 1'b1;
          end else if (!mem_rvalid) begin
            state_d = S_WAIT;
            cnt_d   = CNT_W'(1);
          end
        end
      end
      S_WAIT: begin
        if (mem_rvalid) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(WAIT_LIMIT)) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          to_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      size_q     <= 2'b00;
      lane_q     <= 2'b00;
      zext_q     <= 1'b0;
      rd_q       <= 5'd0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= 5'd0;
      rf_wdata_q <= '0;
      mis_q      <= 1'b0;
      to_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      size_q     <= size_d;
      lane_q     <= lane_d;
      zext_q     <= zext_d;
      rd_q       <= rd_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      mis_q      <= mis_d;
      to_q       <= to_d;
    end
  end

  assign rf_we        = rf_we_q;
  assign rf_waddr     = rf_waddr_q;
  assign rf_wdata     = rf_wdata_q;
  assign misalign_err = mis_q;
  assign timeout_err  = to_q;

endmodule
`default_nettype wire

// File: tb/tb_lsu_wb.sv
`default_nettype none
// ============================================================================
// Module  : tb_lsu_wb
// Brief   : Self-checking bench for lsu_wb against a transaction-level model.
// Revision: 1.0
// ============================================================================
module tb_lsu_wb;

  localparam int DATA_W     = 32;
  localparam int WAIT_LIMIT = 15;

  logic              clk = 1'b0;
  logic              rst;
  logic              is_load_in, zero_ext_in, is_nop_in;
  logic [1:0]        size_in, addr_lo_in;
  logic [4:0]        rd_in;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;
  logic              rf_we, stall_out, misalign_err, timeout_err;
  logic [4:0]        rf_waddr;
  logic [DATA_W-1:0] rf_wdata;

  always #5 clk = ~clk;

  lsu_wb #(.DATA_W(DATA_W), .WAIT_LIMIT(WAIT_LIMIT)) dut (
    .clk          (clk),
    .rst          (rst),
    .is_load_in   (is_load_in),
    .zero_ext_in  (zero_ext_in),
    .is_nop_in    (is_nop_in),
    .size_in      (size_in),
    .rd_in        (rd_in),
    .addr_lo_in   (addr_lo_in),
    .mem_rvalid   (mem_rvalid),
    .mem_rdata    (mem_rdata),
    .rf_we        (rf_we),
    .rf_waddr     (rf_waddr),
    .rf_wdata     (rf_wdata),
    .stall_out    (stall_out),
    .misalign_err (misalign_err),
    .timeout_err  (timeout_err)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: one outstanding load, tracked by how long it has waited.
  bit     m_pend;
  int     m_waited;
  int     m_size, m_lane, m_rd;
  bit     m_zext;
  bit     e_we, e_mis, e_to;
  int     e_waddr;
  longint e_wdata;
  int     stall_cnt, to_cnt, mis_cnt;

  function automatic int nbytes(input int size);
    return (size >= 2) ? 4 : (1 << size);
  endfunction

  function automatic bit ref_misaligned(input int size, input int lane);
    return (lane % nbytes(size)) != 0;
  endfunction

  function automatic longint ref_extract(input longint word, input int size, input int lane, input bit zext);
    longint mask;
    longint v;
    int     n;
    n    = nbytes(size);
    mask = (longint'(1) << (8 * n)) - 1;
    v    = (word >> (8 * lane)) & mask;
    if (!zext && (((v >> (8 * n - 1)) & 1) == 1)) v = v | ~mask;
    return v & 64'hFFFF_FFFF;
  endfunction

  task automatic step(input bit ld, input bit nop, input bit zx, input int sz, input int rd,
                      input int ln, input bit rv, input logic [31:0] data, input bit r);
    bit acc, exp_stall, mis;
    rst         = r;
    is_load_in  = ld;
    is_nop_in   = nop;
    zero_ext_in = zx;
    size_in     = sz[1:0];
    rd_in       = rd[4:0];
    addr_lo_in  = ln[1:0];
    mem_rvalid  = rv;
    mem_rdata   = data;
    #3;
    acc       = !m_pend && ld && !nop;
    mis       = ref_misaligned(sz, ln);
    exp_stall = m_pend || (acc && !mis && !rv);
    if (!r) chk("stall", {63'd0, stall_out}, {63'd0, exp_stall});
    if (stall_out) stall_cnt++;

    e_we = 0; e_mis = 0; e_to = 0;
    if (r) begin
      m_pend = 0;
    end else if (m_pend) begin
      if (rv) begin
        e_we    = (m_rd != 0);
        e_waddr = m_rd;
        e_wdata = ref_extract(longint'(data), m_size, m_lane, m_zext);
        m_pend  = 0;
      end else if (m_waited == WAIT_LIMIT) begin
        e_to   = 1;
        m_pend = 0;
      end else begin
        m_waited++;
      end
    end else if (acc) begin
      if (mis) begin
        e_mis = 1;
      end else if (rv) begin
        e_we    = (rd != 0);
        e_waddr = rd;
        e_wdata = ref_extract(longint'(data), sz, ln, zx);
      end else begin
        m_pend = 1; m_waited = 1;
        m_size = sz; m_lane = ln; m_rd = rd; m_zext = zx;
      end
    end

    @(posedge clk);
    #1;
    if (timeout_err) to_cnt++;
    if (misalign_err) mis_cnt++;
    if (r) begin
      chk("rst_we",    {63'd0, rf_we}, 64'd0);
      chk("rst_waddr", {59'd0, rf_waddr}, 64'd0);
      chk("rst_wdata", {32'd0, rf_wdata}, 64'd0);
      chk("rst_mis",   {63'd0, misalign_err}, 64'd0);
      chk("rst_to",    {63'd0, timeout_err}, 64'd0);
    end else begin
      chk("we",  {63'd0, rf_we}, {63'd0, e_we});
      chk("mis", {63'd0, misalign_err}, {63'd0, e_mis});
      chk("to",  {63'd0, timeout_err}, {63'd0, e_to});
      if (e_we) begin
        chk("waddr", {59'd0, rf_waddr}, longint'(e_waddr));
        chk("wdata", {32'd0, rf_wdata}, e_wdata);
      end
    end
  endtask

  task automatic idle(input bit rv);
    step(0, 0, 0, 0, 0, 0, rv, $urandom, 0);
  endtask

  task automatic noise(input bit rv);
    step(1, 0, $urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 31),
         $urandom_range(0, 3), rv, $urandom, 0);
  endtask

  initial begin
    int rv_pct;
    m_pend = 0; m_waited = 0; stall_cnt = 0; to_cnt = 0; mis_cnt = 0;
    rst = 1; is_load_in = 0; is_nop_in = 0; zero_ext_in = 0; size_in = 0;
    rd_in = 0; addr_lo_in = 0; mem_rvalid = 0; mem_rdata = 0;
    #1;

    step(1, 0, 0, 2, 3, 0, 0, 32'h0, 1);
    step(0, 0, 0, 0, 0, 0, 1, 32'hFFFF_FFFF, 1);
    idle(0);
    chk("reset_stall", {63'd0, stall_out}, 64'd0);

    // Byte, sign-extended, immediate response
    stall_cnt = 0;
    step(1, 0, 0, 0, 5, 3, 1, 32'h80FF_1234, 0);
    chk("t1_we",    {63'd0, rf_we}, 64'd1);
    chk("t1_waddr", {59'd0, rf_waddr}, 64'd5);
    chk("t1_wdata", {32'd0, rf_wdata}, 64'hFFFF_FF80);
    idle(0);
    chk("t1_stall", longint'(stall_cnt), 64'd0);

    // Half, zero-extended, response after 3 cycles; inputs in WAIT are garbage
    stall_cnt = 0;
    step(1, 0, 1, 1, 7, 2, 0, 32'h0, 0);
    noise(0);
    noise(0);
    step(1, 0, 0, 0, 9, 1, 1, 32'hBEEF_0000, 0);
    chk("t2_wdata", {32'd0, rf_wdata}, 64'h0000_BEEF);
    chk("t2_waddr", {59'd0, rf_waddr}, 64'd7);
    chk("t2_stall", longint'(stall_cnt), 64'd4);
    idle(0);
    chk("t2_pulse", {63'd0, rf_we}, 64'd0);

    // Misaligned word and half
    stall_cnt = 0;
    step(1, 0, 0, 2, 9, 1, 1, 32'h1234_5678, 0);
    chk("t3_word_mis", {63'd0, misalign_err}, 64'd1);
    step(1, 0, 0, 1, 9, 3, 0, 32'h1234_5678, 0);
    chk("t3_half_mis", {63'd0, misalign_err}, 64'd1);
    chk("t3_we", {63'd0, rf_we}, 64'd0);
    chk("t3_stall", longint'(stall_cnt), 64'd0);

    // Timeout, then the next load is accepted
    stall_cnt = 0; to_cnt = 0;
    step(1, 0, 0, 2, 4, 0, 0, 32'h0, 0);
    for (int i = 0; i < 20; i++) idle(0);
    chk("t4_stall", longint'(stall_cnt), 64'd16);
    chk("t4_to_cnt", longint'(to_cnt), 64'd1);
    step(1, 0, 0, 2, 4, 0, 1, 32'hCAFE_F00D, 0);
    chk("t4_after", {32'd0, rf_wdata}, 64'hCAFE_F00D);

    // Reset in WAIT, then late response
    to_cnt = 0;
    step(1, 0, 0, 2, 6, 0, 0, 32'h0, 0);
    idle(0);
    step(0, 0, 0, 0, 0, 0, 0, 32'h0, 1);
    idle(1);
    chk("t5_we", {63'd0, rf_we}, 64'd0);
    chk("t5_stall", {63'd0, stall_out}, 64'd0);
    for (int i = 0; i < 20; i++) idle(0);
    chk("t5_to", longint'(to_cnt), 64'd0);

    // NOP, store, load to x0
    stall_cnt = 0;
    step(1, 1, 0, 2, 8, 0, 1, 32'h1111_2222, 0);
    step(0, 0, 0, 2, 8, 0, 1, 32'h3333_4444, 0);
    step(1, 0, 0, 2, 0, 0, 1, 32'h1234_5678, 0);
    chk("t6_we", {63'd0, rf_we}, 64'd0);
    chk("t6_stall", longint'(stall_cnt), 64'd0);

    // Randomized traffic against the model
    rv_pct = 50;
    for (int i = 0; i < 3000; i++) begin
      if (i % 64 == 0) begin
        case ($urandom_range(0, 3))
          0: rv_pct = 0;
          1: rv_pct = 30;
          2: rv_pct = 70;
          default: rv_pct = 100;
        endcase
      end
      step($urandom_range(0, 99) < 60, $urandom_range(0, 99) < 15, $urandom_range(0, 1),
           $urandom_range(0, 3), $urandom_range(0, 31), $urandom_range(0, 3),
           $urandom_range(0, 99) < rv_pct, $urandom, $urandom_range(0, 99) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
